usb_bitstream_readback_tx: RTL and testbench

//  Device-to-host counterpart of the USB-UART bridge receive path: takes 32-bit configuration/readback

---
 rtl/usb_bitstream_readback_tx.sv | 183 ++++++++++++++++++
 tb/tb_usb_bitstream_readback_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bitstream_readback_tx.sv
// Frames 32-bit readback words into a byte stream for the USB CDC IN path: sync word, 16-bit count, data, optional checksum.
// Define READBACK_CHECKSUM_EN to append an XOR checksum byte after the payload.
module usb_bitstream_readback_tx #(
    parameter logic [31:0] SYNC_WORD = 32'hFAB0_FAB1,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] word_count_i,
    input  logic [31:0]        word_data_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    output logic [7:0]         in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
`ifdef READBACK_CHECKSUM_EN
        , ST_CSUM = 3'd5
`endif
    } state_t;

`ifdef READBACK_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef READBACK_CHECKSUM_EN
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [7:0]         csum_r;
`endif

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         byte_idx_r;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] words_left_r;
    logic [31:0]        hold_r;
    logic               full_r;
    logic [7:0]         in_data_s;
    logic               in_valid_s;
    logic               accept_s;
    logic               last_byte_s;
    logic               word_ready_s;
    logic               take_s;

    // Byte source selection for the current frame field.
    always_comb begin
        in_data_s  = 8'h00;
        in_valid_s = 1'b0;
        case (state_r)
            ST_SYNC: begin
                in_data_s  = word_byte(SYNC_WORD, byte_idx_r);
                in_valid_s = 1'b1;
            end
            ST_COUNT: begin
                in_data_s  = (byte_idx_r == 2'd0) ? count_r[15:8] : count_r[7:0];
                in_valid_s = 1'b1;
            end
            ST_DATA: begin
                in_data_s  = word_byte(hold_r, byte_idx_r);
                in_valid_s = full_r;
            end
`ifdef READBACK_CHECKSUM_EN
            ST_CSUM: begin
                in_data_s  = csum_r;
                in_valid_s = 1'b1;
            end
`endif
            default: begin
                in_data_s  = 8'h00;
                in_valid_s = 1'b0;
            end
        endcase
    end

    // A new word may refill the holding register in the same cycle its predecessor drains.
    assign accept_s     = in_valid_s && in_ready_i;
    assign last_byte_s  = (state_r == ST_DATA) && full_r && (byte_idx_r == 2'd3) && accept_s;
    assign word_ready_s = (state_r == ST_DATA) && (words_left_r != '0) && (!full_r || last_byte_s);
    assign take_s       = word_ready_s && word_valid_i;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = start_i ? ST_SYNC : ST_IDLE;
            ST_SYNC:  state_nxt_s = (accept_s && (byte_idx_r == 2'd3)) ? ST_COUNT : ST_SYNC;
            ST_COUNT: begin
                if (accept_s && (byte_idx_r == 2'd1)) begin
                    state_nxt_s = (count_r == '0) ? ST_TAIL : ST_DATA;
                end else begin
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_DATA:  state_nxt_s = (last_byte_s && (words_left_r == '0)) ? ST_TAIL : ST_DATA;
`ifdef READBACK_CHECKSUM_EN
            ST_CSUM:  state_nxt_s = accept_s ? ST_DONE : ST_CSUM;
`endif
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame datapath: byte index, counters, holding register and checksum.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            byte_idx_r   <= 2'd0;
            count_r      <= '0;
            words_left_r <= '0;
            hold_r       <= 32'h0000_0000;
            full_r       <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else if ((state_r == ST_IDLE) && start_i) begin
            byte_idx_r   <= 2'd0;
            count_r      <= word_count_i;
            words_left_r <= word_count_i;
            full_r       <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            if (accept_s) begin
                byte_idx_r <= ((state_r == ST_COUNT) && (byte_idx_r == 2'd1)) ? 2'd0 : byte_idx_r + 2'd1;
            end
            if (take_s) begin
                hold_r       <= word_data_i;
                full_r       <= 1'b1;
                words_left_r <= words_left_r - COUNT_W'(1);
            end else if (last_byte_s) begin
                full_r <= 1'b0;
            end
`ifdef READBACK_CHECKSUM_EN
            if (accept_s) begin
                csum_r <= csum_update(csum_r, in_data_s);
            end
`endif
        end
    end

    assign in_data_o    = in_data_s;
    assign in_valid_o   = in_valid_s;
    assign word_ready_o = word_ready_s;
    assign done_o       = (state_r == ST_DONE);
    assign busy_o       = (state_r != ST_IDLE) && (state_r != ST_DONE);

endmodule

// File: tb/tb_usb_bitstream_readback_tx.sv
// Randomised bench for usb_bitstream_readback_tx: frames are rebuilt from the word list and compared byte by byte.
module tb_usb_bitstream_readback_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] word_count = 16'h0000;
    logic [31:0] word_data = 32'h0000_0000;
    logic        word_valid = 1'b0;
    logic        in_ready = 1'b0;
    logic        word_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] words_q[$];
    logic [7:0]  got_bytes[$];
    logic [7:0]  exp_bytes[$];
    int done_cnt, stall_err, ready_bad, busy_bad, taken, post_bad;
    bit timeout;

    usb_bitstream_readback_tx dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .word_count_i (word_count),
        .word_data_i  (word_data),
        .word_valid_i (word_valid),
        .word_ready_o (word_ready),
        .in_data_o    (in_data),
        .in_valid_o   (in_valid),
        .in_ready_i   (in_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_words(input int cnt);
        words_q.delete();
        for (int i = 0; i < cnt; i++) words_q.push_back($urandom);
    endtask

    // Reference frame: sync, count, words MSB first, then XOR of everything so far when enabled.
    task automatic build_expected(input int cnt);
        logic [31:0] s;
        logic [15:0] c;
        logic [7:0]  x;
        s = 32'hFAB0_FAB1;
        c = cnt[15:0];
        exp_bytes.delete();
        for (int b = 3; b >= 0; b--) exp_bytes.push_back(s[8*b +: 8]);
        exp_bytes.push_back(c[15:8]);
        exp_bytes.push_back(c[7:0]);
        foreach (words_q[i]) for (int b = 3; b >= 0; b--) exp_bytes.push_back(words_q[i][8*b +: 8]);
        x = 8'h00;
        foreach (exp_bytes[i]) x = x ^ exp_bytes[i];
`ifdef READBACK_CHECKSUM_EN
        exp_bytes.push_back(x);
`endif
    endtask

    // Runs one frame and records observations; poke holds start high and forces word_valid early.
    task automatic run_frame(input int cnt, input int rdy_pct, input int vld_pct, input bit poke, input int abort_after);
        int cyc;
        bit prev_stall, saw_done;
        logic [7:0] prev_data;
        got_bytes.delete();
        done_cnt = 0; stall_err = 0; ready_bad = 0; busy_bad = 0; taken = 0; post_bad = 0; timeout = 1'b0;
        cyc = 0; prev_stall = 1'b0; saw_done = 1'b0; prev_data = 8'h00;
        @(posedge clk); #1;
        start = 1'b1; word_count = cnt[15:0];
        @(posedge clk); #1;
        forever begin
            start = poke;
            if (poke) word_count = 16'h0007;
            in_ready   = ($urandom_range(99) < rdy_pct);
            word_valid = (poke && cyc < 3) ? 1'b1 : ($urandom_range(99) < vld_pct);
            word_data  = (taken < cnt) ? words_q[taken] : $urandom;
            @(negedge clk);
            if (prev_stall && (!in_valid || in_data !== prev_data)) stall_err++;
            if (word_ready && (got_bytes.size() < 6 || taken >= cnt)) ready_bad++;
            if (word_valid && word_ready) taken++;
            if (in_valid && in_ready) got_bytes.push_back(in_data);
            prev_stall = in_valid && !in_ready;
            prev_data  = in_data;
            if (done) begin
                done_cnt++;
                if (busy) busy_bad++;
                saw_done = 1'b1;
            end
            cyc++;
            if (saw_done || cyc > 4000 || (abort_after > 0 && got_bytes.size() == abort_after)) break;
            @(posedge clk); #1;
        end
        start = 1'b0; word_valid = 1'b0;
        timeout = !saw_done && (abort_after == 0);
        if (saw_done) begin
            repeat (3) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (done) done_cnt++;
                if (in_valid || busy || word_ready) post_bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++; if (in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_in_valid: got %b expected 0", in_valid); end
        vectors++; if (in_data !== 8'h00) begin miscompares++; $display("FAIL reset_in_data: got %h expected 00", in_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (word_ready !== 1'b0) begin miscompares++; $display("FAIL reset_word_ready: got %b expected 0", word_ready); end
    endtask

    task automatic test_one_word();
        words_q.delete();
        words_q.push_back(32'h1234_5678);
        build_expected(1);
        run_frame(1, 100, 100, 1'b0, 0);
        vectors++; if (got_bytes.size() !== exp_bytes.size()) begin miscompares++; $display("FAIL one_word_len: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size(); i++) begin
            vectors++; if (i >= got_bytes.size() || got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL one_word_byte%0d: got %h expected %h", i, (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, exp_bytes[i]); end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL one_word_done: got %0d pulses expected 1", done_cnt); end
        vectors++; if (taken !== 1) begin miscompares++; $display("FAIL one_word_taken: got %0d expected 1", taken); end
        vectors++; if (ready_bad !== 0 || busy_bad !== 0 || post_bad !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL one_word_ctrl: got rdy %0d busy %0d post %0d to %0d expected all 0", ready_bad, busy_bad, post_bad, timeout); end
    endtask

    task automatic test_zero_count();
        words_q.delete();
        build_expected(0);
        run_frame(0, 100, 100, 1'b0, 0);
        vectors++; if (got_bytes.size() !== exp_bytes.size()) begin miscompares++; $display("FAIL zero_len: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size(); i++) begin
            vectors++; if (i >= got_bytes.size() || got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL zero_byte%0d: got %h expected %h", i, (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, exp_bytes[i]); end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL zero_done: got %0d pulses expected 1", done_cnt); end
        vectors++; if (taken !== 0 || ready_bad !== 0) begin miscompares++; $display("FAIL zero_word_ready: got taken %0d bad %0d expected 0 0", taken, ready_bad); end
    endtask

    task automatic test_random_stall();
        for (int f = 0; f < 5; f++) begin
            int cnt;
            cnt = (f == 0) ? 3 : int'($urandom_range(6, 1));
            fill_words(cnt);
            build_expected(cnt);
            run_frame(cnt, 50, 50, 1'b0, 0);
            vectors++; if (got_bytes.size() !== exp_bytes.size()) begin miscompares++; $display("FAIL stall%0d_len: got %0d expected %0d", f, got_bytes.size(), exp_bytes.size()); end
            for (int i = 0; i < exp_bytes.size(); i++) begin
                vectors++; if (i >= got_bytes.size() || got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL stall%0d_byte%0d: got %h expected %h", f, i, (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, exp_bytes[i]); end
            end
            vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL stall%0d_stable: got %0d unstable cycles expected 0", f, stall_err); end
            vectors++; if (done_cnt !== 1 || taken !== cnt) begin miscompares++; $display("FAIL stall%0d_done: got done %0d taken %0d expected 1 %0d", f, done_cnt, taken, cnt); end
            vectors++; if (ready_bad !== 0 || busy_bad !== 0 || post_bad !== 0 || timeout !== 1'b0) begin miscompares++; $display("FAIL stall%0d_ctrl: got rdy %0d busy %0d post %0d to %0d expected all 0", f, ready_bad, busy_bad, post_bad, timeout); end
        end
    endtask

    task automatic test_ignore_inputs();
        fill_words(2);
        build_expected(2);
        run_frame(2, 70, 60, 1'b1, 0);
        vectors++; if (got_bytes.size() !== exp_bytes.size()) begin miscompares++; $display("FAIL ignore_len: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size(); i++) begin
            vectors++; if (i >= got_bytes.size() || got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL ignore_byte%0d: got %h expected %h", i, (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, exp_bytes[i]); end
        end
        vectors++; if (ready_bad !== 0) begin miscompares++; $display("FAIL ignore_word_ready: got %0d early/extra accepts expected 0", ready_bad); end
        vectors++; if (done_cnt !== 1 || post_bad !== 0) begin miscompares++; $display("FAIL ignore_restart: got done %0d post %0d expected 1 0", done_cnt, post_bad); end
    endtask

    task automatic test_reset_mid_frame();
        fill_words(2);
        build_expected(2);
        run_frame(2, 100, 100, 1'b0, 7);
        vectors++; if (got_bytes.size() !== 7 || done_cnt !== 0) begin miscompares++; $display("FAIL abort_prefix: got %0d bytes done %0d expected 7 0", got_bytes.size(), done_cnt); end
        for (int i = 0; i < 7 && i < got_bytes.size(); i++) begin
            vectors++; if (got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL abort_byte%0d: got %h expected %h", i, got_bytes[i], exp_bytes[i]); end
        end
        @(posedge clk); #1;
        reset = 1'b1; in_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (in_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_after_reset: got valid %b busy %b done %b expected 0 0 0", in_valid, busy, done); end
        post_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_valid || busy || done) post_bad++;
        end
        vectors++; if (post_bad !== 0) begin miscompares++; $display("FAIL abort_idle: got %0d active cycles expected 0", post_bad); end
        fill_words(2);
        build_expected(2);
        run_frame(2, 80, 80, 1'b0, 0);
        vectors++; if (got_bytes.size() !== exp_bytes.size() || done_cnt !== 1) begin miscompares++; $display("FAIL abort_refresh: got %0d bytes done %0d expected %0d 1", got_bytes.size(), done_cnt, exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
            vectors++; if (got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL abort_refresh_byte%0d: got %h expected %h", i, got_bytes[i], exp_bytes[i]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            int cnt;
            cnt = int'($urandom_range(4, 0));
            fill_words(cnt);
            build_expected(cnt);
            run_frame(cnt, 100, 100, 1'b0, 0);
            vectors++; if (got_bytes.size() !== exp_bytes.size() || done_cnt !== 1) begin miscompares++; $display("FAIL b2b%0d_frame: got %0d bytes done %0d expected %0d 1", f, got_bytes.size(), done_cnt, exp_bytes.size()); end
            for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
                vectors++; if (got_bytes[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL b2b%0d_byte%0d: got %h expected %h", f, i, got_bytes[i], exp_bytes[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_zero_count();
        test_random_stall();
        test_ignore_inputs();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
